pattern_scheduler: RTL and testbench

Frame-synchronous controller that sequences the test-pattern datapath through its pattern set. It sits between the video sync generator (frame timing) and the pattern generator (pattern select and blanking). It advances the active pattern on a user request or, optionally, on an auto-advance timer, and changes pattern only at a frame boundary. Each change is preceded by a configurable number of all-black frames.

---
 rtl/pattern_sched_pkg.sv | 20 ++
 rtl/vblank_edge_detect.sv | 26 ++
 rtl/pattern_scheduler.sv | 173 +++++++++++++++++
 tb/tb_pattern_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sched_pkg.sv
// Shared definitions for the pattern scheduler and related frame-synchronous blocks.
// This package holds the scheduler state enum, the counter widths and the default
// configuration constants.
package pattern_sched_pkg;

    // Scheduler states: SHOW displays the active pattern, BLANK inserts black frames.
    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } sched_state_e;

    localparam int FRAME_CNT_W      = 16;
    localparam int BLANK_CNT_W      = 8;
    localparam int AUTO_CNT_W       = 16;

    localparam int DEF_NUM_PATTERNS = 8;
    localparam int DEF_BLANK_FRAMES = 2;
    localparam int DEF_AUTO_FRAMES  = 120;

endpackage

// File: rtl/vblank_edge_detect.sv
// Vertical-blank rising-edge detector producing a one-cycle frame tick.
// The registered copy of vblank resets high, so a vblank that is already high
// when reset releases does not produce a tick.
module vblank_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vblank,
    output logic o_tick
);

    logic vblank_q;
    logic vblank_d;

    assign vblank_d = i_vblank;
    assign o_tick   = i_vblank & ~vblank_q;

    // Delay vblank by one cycle for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vblank_q <= 1'b1;
        end else begin
            vblank_q <= vblank_d;
        end
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-synchronous test-pattern scheduler.
// The scheduler advances the pattern select on a request, or on the optional
// auto-advance timer. It changes pattern only at a frame tick, and it inserts
// BLANK_FRAMES black frames before each change.
// Optional feature macro: PATTERN_SCHED_AUTO_EN builds the auto-advance timer.
// Without this macro, i_auto_en is ignored and AUTO_FRAMES is unused.
module pattern_scheduler
    import pattern_sched_pkg::*;
#(
    parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int SEL_W        = 3,
    parameter int BLANK_FRAMES = DEF_BLANK_FRAMES,
    parameter int AUTO_FRAMES  = DEF_AUTO_FRAMES
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_vblank,
    input  logic                   i_next,
    input  logic                   i_auto_en,
    output logic [SEL_W-1:0]       o_pattern_sel,
    output logic                   o_blank,
    output logic                   o_switch,
    output logic [FRAME_CNT_W-1:0] o_frame_count
);

    localparam logic [SEL_W-1:0]       SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [BLANK_CNT_W-1:0] BLANK_LAST = BLANK_CNT_W'(BLANK_FRAMES - 1);

    // Next pattern index, wrapping after the last pattern.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
        if (cur == SEL_LAST) begin
            next_sel = {SEL_W{1'b0}};
        end else begin
            next_sel = cur + SEL_W'(1);
        end
    endfunction

    logic                   tick_s;
    logic                   start_s;
    logic                   auto_hit_s;

    sched_state_e           state_q,     state_d;
    logic                   pending_q,   pending_d;
    logic [BLANK_CNT_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [SEL_W-1:0]       sel_q,       sel_d;
    logic                   blank_q,     blank_d;
    logic                   switch_q,    switch_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    vblank_edge_detect u_vblank_edge (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_vblank (i_vblank),
        .o_tick   (tick_s)
    );

    // A transition starts on a tick in SHOW when a request is pending. A request
    // arriving on the same cycle as the tick counts as pending.
    assign start_s = tick_s && (state_q == SHOW) && (pending_q || i_next || auto_hit_s);

`ifdef PATTERN_SCHED_AUTO_EN
    localparam logic [AUTO_CNT_W-1:0] AUTO_LAST = AUTO_CNT_W'(AUTO_FRAMES - 1);

    logic [AUTO_CNT_W-1:0] auto_cnt_q, auto_cnt_d;

    assign auto_hit_s = i_auto_en && (auto_cnt_q == AUTO_LAST);

    // Count displayed frames while auto-advance is enabled. The count is held at
    // zero while disabled and restarts when a transition begins.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (!i_auto_en) begin
            auto_cnt_d = {AUTO_CNT_W{1'b0}};
        end else if (start_s) begin
            auto_cnt_d = {AUTO_CNT_W{1'b0}};
        end else if (tick_s && (state_q == SHOW)) begin
            auto_cnt_d = auto_cnt_q + AUTO_CNT_W'(1);
        end else begin
            auto_cnt_d = auto_cnt_q;
        end
    end

    // Auto-advance frame counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            auto_cnt_q <= {AUTO_CNT_W{1'b0}};
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    localparam int unused_auto_frames = AUTO_FRAMES;
    logic unused_auto_en_s;

    assign unused_auto_en_s = i_auto_en;
    assign auto_hit_s       = 1'b0;
`endif

    // Next-state logic for the sequencer, request latch, counters and outputs.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | i_next;
        blank_cnt_d = blank_cnt_q;
        sel_d       = sel_q;
        blank_d     = blank_q;
        switch_d    = 1'b0;

        if (tick_s) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        case (state_q)
            SHOW: begin
                if (start_s) begin
                    state_d     = BLANK;
                    blank_cnt_d = {BLANK_CNT_W{1'b0}};
                    blank_d     = 1'b1;
                    pending_d   = 1'b0;
                end else begin
                    state_d     = SHOW;
                end
            end
            BLANK: begin
                if (tick_s) begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_d  = SHOW;
                        blank_d  = 1'b0;
                        switch_d = 1'b1;
                        sel_d    = next_sel(sel_q);
                    end else begin
                        blank_cnt_d = blank_cnt_q + BLANK_CNT_W'(1);
                    end
                end else begin
                    state_d = BLANK;
                end
            end
            default: begin
                state_d     = SHOW;
                blank_cnt_d = {BLANK_CNT_W{1'b0}};
                blank_d     = 1'b0;
            end
        endcase
    end

    // State, latch, counter and registered-output flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= SHOW;
            pending_q   <= 1'b0;
            blank_cnt_q <= {BLANK_CNT_W{1'b0}};
            sel_q       <= {SEL_W{1'b0}};
            blank_q     <= 1'b0;
            switch_q    <= 1'b0;
            frame_cnt_q <= {FRAME_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            blank_cnt_q <= blank_cnt_d;
            sel_q       <= sel_d;
            blank_q     <= blank_d;
            switch_q    <= switch_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_pattern_sel = sel_q;
    assign o_blank       = blank_q;
    assign o_switch      = switch_q;
    assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed testbench for pattern_scheduler with NUM_PATTERNS=8, BLANK_FRAMES=2
// and AUTO_FRAMES=4.
module tb_pattern_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        nxt;
    logic        auto_en;
    logic [2:0]  sel;
    logic        blank;
    logic        sw;
    logic [15:0] fc;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_fc   = 0;
    logic exp_b;

    always #5 clk = ~clk;

    pattern_scheduler #(
        .NUM_PATTERNS (8),
        .SEL_W        (3),
        .BLANK_FRAMES (2),
        .AUTO_FRAMES  (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_vblank      (vblank),
        .i_next        (nxt),
        .i_auto_en     (auto_en),
        .o_pattern_sel (sel),
        .o_blank       (blank),
        .o_switch      (sw),
        .o_frame_count (fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The caller is at a negedge with vblank low. The next posedge is the frame tick.
    task automatic vb_rise();
        vblank = 1'b1;
        @(negedge clk);
        exp_fc++;
    endtask

    // Hold vblank for the rest of the blank interval, then drop it for the active lines.
    task automatic frame_tail();
        repeat (2) @(negedge clk);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_next();
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        @(negedge clk);
    endtask

    // Perform one complete request-driven transition.
    task automatic advance();
        pulse_next();
        for (int f = 0; f < 3; f++) begin
            vb_rise();
            frame_tail();
        end
    endtask

    initial begin
        rst     = 1'b1;
        vblank  = 1'b1;
        nxt     = 1'b0;
        auto_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_blank", 32'(blank), 32'd0);
        check("rst_switch", 32'(sw), 32'd0);
        check("rst_fc", 32'(fc), 32'd0);

        // Release reset while vblank is already high. No tick is expected.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_tick_fc", 32'(fc), 32'd0);
        check("no_tick_blank", 32'(blank), 32'd0);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        vb_rise();
        check("first_tick_fc", 32'(fc), 32'(exp_fc));
        check("first_tick_blank", 32'(blank), 32'd0);
        frame_tail();

        // A single request mid-frame gives two black frames, then sel becomes 1.
        pulse_next();
        check("pre_tick_blank", 32'(blank), 32'd0);
        vb_rise();
        check("req_blank_on", 32'(blank), 32'd1);
        check("req_sel_hold", 32'(sel), 32'd0);
        frame_tail();
        vb_rise();
        check("req_blank_mid", 32'(blank), 32'd1);
        check("req_sw_mid", 32'(sw), 32'd0);
        frame_tail();
        vb_rise();
        check("req_blank_off", 32'(blank), 32'd0);
        check("req_sel1", 32'(sel), 32'd1);
        check("req_sw_pulse", 32'(sw), 32'd1);
        check("req_fc", 32'(fc), 32'(exp_fc));
        @(negedge clk);
        check("req_sw_single", 32'(sw), 32'd0);
        frame_tail();

        // Three requests within one frame merge into a single advance.
        pulse_next();
        pulse_next();
        pulse_next();
        for (int f = 0; f < 3; f++) begin
            vb_rise();
            frame_tail();
        end
        check("merge_sel2", 32'(sel), 32'd2);
        vb_rise();
        check("merge_no_second", 32'(blank), 32'd0);
        check("merge_sel_hold", 32'(sel), 32'd2);
        frame_tail();

        // A request on the same cycle as the tick starts BLANK at that edge.
        nxt = 1'b1;
        vb_rise();
        nxt = 1'b0;
        check("same_cycle_blank", 32'(blank), 32'd1);
        frame_tail();
        pulse_next();
        vb_rise();
        frame_tail();
        vb_rise();
        check("same_cycle_sel3", 32'(sel), 32'd3);
        check("same_cycle_unblank", 32'(blank), 32'd0);
        frame_tail();
        // The request made during BLANK is serviced at the next tick.
        vb_rise();
        check("held_req_blank", 32'(blank), 32'd1);
        frame_tail();
        vb_rise();
        frame_tail();
        vb_rise();
        check("held_req_sel4", 32'(sel), 32'd4);
        frame_tail();

        // Wrap from the last pattern back to pattern 0.
        for (int a = 0; a < 3; a++) advance();
        check("sel7", 32'(sel), 32'd7);
        pulse_next();
        vb_rise(); frame_tail();
        vb_rise(); frame_tail();
        vb_rise();
        check("wrap_sel0", 32'(sel), 32'd0);
        check("wrap_sw", 32'(sw), 32'd1);
        frame_tail();

        // Assert reset in BLANK at sel=3. The outputs clear asynchronously.
        for (int a = 0; a < 3; a++) advance();
        check("pre_rst_sel3", 32'(sel), 32'd3);
        pulse_next();
        vb_rise();
        check("pre_rst_blank", 32'(blank), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_blank", 32'(blank), 32'd0);
        check("arst_sw", 32'(sw), 32'd0);
        check("arst_fc", 32'(fc), 32'd0);
        exp_fc = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_tick", 32'(fc), 32'd0);
        frame_tail();
        pulse_next();
        vb_rise();
        check("post_rst_blank", 32'(blank), 32'd1);
        check("post_rst_fc", 32'(fc), 32'(exp_fc));
        frame_tail();
        vb_rise(); frame_tail();
        vb_rise();
        check("post_rst_sel1", 32'(sel), 32'd1);
        frame_tail();

        // Auto-advance. Without the feature, the selection never moves.
        auto_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vb_rise();
`ifdef PATTERN_SCHED_AUTO_EN
            exp_b = (k == 3);
`else
            exp_b = 1'b0;
`endif
            check("auto_blank", 32'(blank), 32'(exp_b));
            check("auto_fc", 32'(fc), 32'(exp_fc));
            frame_tail();
        end
        auto_en = 1'b0;
        vb_rise(); frame_tail();
        vb_rise();
`ifdef PATTERN_SCHED_AUTO_EN
        check("auto_sel", 32'(sel), 32'd2);
`else
        check("auto_sel", 32'(sel), 32'd1);
`endif
        frame_tail();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
